// File: rtl/saturn_bus_pkg.sv
// rtl/saturn_bus_pkg.sv - shared state encoding, requester IDs and width defaults for the ROM arbiter
package saturn_bus_pkg;

  localparam int ADDR_W_DEFAULT = 20;
  localparam int LEN_W_DEFAULT  = 4;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/saturn_mem_arbiter_if.sv
// rtl/saturn_mem_arbiter_if.sv - requester, ROM port and status signals of the Saturn ROM arbiter
interface saturn_mem_arbiter_if
  import saturn_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [LEN_W-1:0]  if_len;
  logic              if_ack;
  logic              if_valid;
  logic [3:0]        if_nibble;
  logic              if_done;

  logic              dt_req;
  logic [ADDR_W-1:0] dt_addr;
  logic [LEN_W-1:0]  dt_len;
  logic              dt_ack;
  logic              dt_valid;
  logic [3:0]        dt_nibble;
  logic              dt_done;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_nibble;

  logic              busy;
  logic              owner_dt;

  modport slave (
    input  if_req, if_addr, if_len, dt_req, dt_addr, dt_len, mem_nibble,
    output if_ack, if_valid, if_nibble, if_done,
    output dt_ack, dt_valid, dt_nibble, dt_done,
    output mem_en, mem_addr, busy, owner_dt
  );

  modport master (
    output if_req, if_addr, if_len, dt_req, dt_addr, dt_len, mem_nibble,
    input  if_ack, if_valid, if_nibble, if_done,
    input  dt_ack, dt_valid, dt_nibble, dt_done,
    input  mem_en, mem_addr, busy, owner_dt
  );

endinterface

// File: rtl/saturn_burst_seq.sv
// rtl/saturn_burst_seq.sv - burst address sequencer with one-cycle-delayed valid/last return pipeline
module saturn_burst_seq
  import saturn_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              issue,
  output logic              last_issue,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ret_valid,
  output logic              ret_last
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  // One bit wider than len so a 16-nibble burst never wraps before the compare
  logic [LEN_W:0]    k_q, k_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              last_q, last_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ret_last_q, ret_last_d;

  assign last_issue = issue && (k_q == {1'b0, len_q});

  always_comb begin
    base_d      = base_q;
    len_d       = len_q;
    k_d         = k_q;
    mem_en_d    = 1'b0;
    mem_addr_d  = '0;
    last_d      = 1'b0;
    ret_valid_d = mem_en_q;
    ret_last_d  = last_q;
    if (start) begin
      base_d = start_addr;
      len_d  = start_len;
      k_d    = '0;
    end else if (issue) begin
      mem_en_d   = 1'b1;
      mem_addr_d = base_q + ADDR_W'(k_q);
      k_d        = k_q + (LEN_W+1)'(1);
      last_d     = last_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      len_q       <= '0;
      k_q         <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      last_q      <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
    end else begin
      base_q      <= base_d;
      len_q       <= len_d;
      k_q         <= k_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      last_q      <= last_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;

endmodule

// File: rtl/saturn_mem_arbiter.sv
// rtl/saturn_mem_arbiter.sv - round-robin burst arbiter sharing the nibble ROM port between fetch and data
module saturn_mem_arbiter
  import saturn_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  saturn_mem_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;
  logic prio_dt_q, prio_dt_d;
  logic owner_dt_q, owner_dt_d;
  logic busy_q, busy_d;
  logic if_ack_q, if_ack_d;
  logic dt_ack_q, dt_ack_d;

  logic              grant_dt;
  logic              start;
  logic              issue;
  logic              last_issue;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  start_len;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              ret_valid;
  logic              ret_last;

  // DT wins when it is alone, or when both ask and the pointer favours DT
  assign grant_dt   = bus.dt_req && (!bus.if_req || prio_dt_q);
  assign start_addr = grant_dt ? bus.dt_addr : bus.if_addr;
  assign start_len  = grant_dt ? bus.dt_len  : bus.if_len;

  always_comb begin
    state_d    = state_q;
    prio_dt_d  = prio_dt_q;
    owner_dt_d = owner_dt_q;
    busy_d     = busy_q;
    if_ack_d   = 1'b0;
    dt_ack_d   = 1'b0;
    start      = 1'b0;
    issue      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.if_req || bus.dt_req) begin
          start      = 1'b1;
          owner_dt_d = grant_dt;
          if_ack_d   = !grant_dt;
          dt_ack_d   = grant_dt;
          busy_d     = 1'b1;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        issue = 1'b1;
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        prio_dt_d = !owner_dt_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prio_dt_q  <= 1'b0;
      owner_dt_q <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      dt_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_dt_q  <= prio_dt_d;
      owner_dt_q <= owner_dt_d;
      busy_q     <= busy_d;
      if_ack_q   <= if_ack_d;
      dt_ack_q   <= dt_ack_d;
    end
  end

  saturn_burst_seq #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .issue      (issue),
    .last_issue (last_issue),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .ret_valid  (ret_valid),
    .ret_last   (ret_last)
  );

  assign bus.mem_en   = mem_en;
  assign bus.mem_addr = mem_addr;
  assign bus.busy     = busy_q;
  assign bus.owner_dt = owner_dt_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.dt_ack   = dt_ack_q;

  // Owner is stable for the whole return window, so gating the shared pipeline is glitch-free
  assign bus.if_valid  = ret_valid && (owner_dt_q == REQ_IF);
  assign bus.if_done   = ret_last  && (owner_dt_q == REQ_IF);
  assign bus.if_nibble = bus.if_valid ? bus.mem_nibble : 4'h0;
  assign bus.dt_valid  = ret_valid && (owner_dt_q == REQ_DT);
  assign bus.dt_done   = ret_last  && (owner_dt_q == REQ_DT);
  assign bus.dt_nibble = bus.dt_valid ? bus.mem_nibble : 4'h0;

endmodule

// File: tb/tb_saturn_mem_arbiter.sv
// tb/tb_saturn_mem_arbiter.sv - randomized self-checking bench for saturn_mem_arbiter
module tb_saturn_mem_arbiter;

  localparam int AW   = 20;
  localparam int LW   = 4;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  saturn_mem_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

  saturn_mem_arbiter #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ROM: data for the address presented in one cycle appears in the next
  always @(posedge clk) bus.mem_nibble <= bus.mem_addr[3:0];

  logic [1:0]    e_ack  [MAXC];
  logic          e_en   [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  logic [11:0]   e_ret  [MAXC];
  logic          e_busy [MAXC];

  int   cyc;
  int   free_at;
  logic m_last_dt;
  logic m_owner;
  logic rst_seen;
  logic keep_if, keep_dt;
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_ack[i]  = 2'b00;
      e_en[i]   = 1'b0;
      e_addr[i] = '0;
      e_ret[i]  = '0;
      e_busy[i] = 1'b0;
    end
  endtask

  // Schedule of one granted burst: ack at grant cycle c, address i at c+1+i, nibble i at c+2+i
  task automatic model_edge();
    logic          g;
    logic [AW-1:0] a;
    logic [AW-1:0] ad;
    logic [5:0]    r;
    int            l;
    cyc++;
    if (reset) begin
      clear_from(cyc);
      free_at   = cyc + 1;
      m_last_dt = 1'b1;
      m_owner   = 1'b0;
    end else if (cyc >= free_at && (bus.if_req || bus.dt_req) && cyc + 24 < MAXC) begin
      if (bus.if_req && bus.dt_req) g = !m_last_dt;
      else                          g = bus.dt_req;
      a = g ? bus.dt_addr : bus.if_addr;
      l = g ? int'(bus.dt_len) : int'(bus.if_len);
      e_ack[cyc] = g ? 2'b10 : 2'b01;
      for (int i = 0; i <= l + 2; i++) e_busy[cyc+i] = 1'b1;
      for (int i = 0; i <= l; i++) begin
        ad = a + AW'(i);
        e_en[cyc+1+i]   = 1'b1;
        e_addr[cyc+1+i] = ad;
        r = {1'b1, (i == l), ad[3:0]};
        e_ret[cyc+2+i] = g ? {6'b0, r} : {r, 6'b0};
      end
      m_owner   = g;
      m_last_dt = g;
      free_at   = cyc + l + 3;
    end
  endtask

  task automatic check_cycle();
    check("ack", 32'({bus.dt_ack, bus.if_ack}), 32'(e_ack[cyc]));
    check("mem_en", 32'(bus.mem_en), 32'(e_en[cyc]));
    if (e_en[cyc] || rst_seen)
      check("mem_addr", 32'(bus.mem_addr), 32'(e_en[cyc] ? e_addr[cyc] : '0));
    check("ret", 32'({bus.if_valid, bus.if_done, bus.if_nibble,
                      bus.dt_valid, bus.dt_done, bus.dt_nibble}), 32'(e_ret[cyc]));
    check("busy", 32'(bus.busy), 32'(e_busy[cyc]));
    check("owner_dt", 32'(bus.owner_dt), 32'(m_owner));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    rst_seen = reset;
    @(negedge clk);
    check_cycle();
    if (bus.if_ack && !keep_if) bus.if_req = 1'b0;
    if (bus.dt_ack && !keep_dt) bus.dt_req = 1'b0;
  endtask

  task automatic raise(input logic r, input logic [AW-1:0] a, input int l);
    if (r) begin
      bus.dt_req  = 1'b1;
      bus.dt_addr = a;
      bus.dt_len  = LW'(l);
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = a;
      bus.if_len  = LW'(l);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] v;
    if ($urandom_range(0, 3) == 0) v = 20'hFFFF0 | AW'($urandom_range(0, 15));
    else                           v = AW'($urandom);
    return v;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    free_at = 0;
    m_last_dt = 1'b1;
    m_owner   = 1'b0;
    rst_seen  = 1'b0;
    keep_if   = 1'b0;
    keep_dt   = 1'b0;
    clear_from(0);
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.if_len  = '0;
    bus.dt_req  = 1'b0;
    bus.dt_addr = '0;
    bus.dt_len  = '0;

    repeat (3) step();
    reset = 1'b0;
    step();

    raise(1'b0, 20'h00100, 4);
    repeat (10) step();

    raise(1'b0, 20'h00040, 0);
    raise(1'b1, 20'h00A37, 0);
    repeat (10) step();

    raise(1'b1, 20'hFFFFE, 3);
    repeat (8) step();

    raise(1'b0, 20'h00010, 15);
    repeat (22) step();

    keep_if = 1'b1;
    keep_dt = 1'b1;
    raise(1'b0, 20'h00300, 1);
    raise(1'b1, 20'h00405, 1);
    repeat (20) step();
    keep_if = 1'b0;
    keep_dt = 1'b0;
    bus.if_req = 1'b0;
    bus.dt_req = 1'b0;
    repeat (6) step();

    raise(1'b0, 20'h00200, 7);
    for (int i = 0; i < 10 && !bus.if_ack; i++) step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    raise(1'b0, 20'h00500, 2);
    raise(1'b1, 20'h00600, 2);
    repeat (12) step();

    for (int n = 0; n < 2500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!bus.if_req) begin
        if ($urandom_range(0, 3) == 0) raise(1'b0, rand_addr(), int'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 39) == 0) begin
        bus.if_req = 1'b0;
      end
      if (!bus.dt_req) begin
        if ($urandom_range(0, 3) == 0) raise(1'b1, rand_addr(), int'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 39) == 0) begin
        bus.dt_req = 1'b0;
      end
      step();
    end
    reset      = 1'b0;
    bus.if_req = 1'b0;
    bus.dt_req = 1'b0;
    repeat (25) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
